pop_count_pipe: RTL and testbench

- Pipelined, parametrised population counter for wide TDC thermometer/sample words, with valid tracking.
- Built from a leaf-chunk popcount plus an adder tree, with STAGES register stages.
- A built-in accumulator sums NUM_ACC consecutive valid counts and emits a multi-sample total for averaging.
- Sits between the TDC sample register and the readout/averaging logic. It replaces single-register pop counting where N is large.

---
 rtl/pop_count_pipe.sv | 136 +++++++++++++
 tb/tb_pop_count_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_count_pipe.sv
// Pipelined population counter for wide TDC sample words: leaf popcounts,
// adder tree with spread registers, valid tracking and an N-sample accumulator.
module pop_count_pipe #(
    parameter int N         = 64,
    parameter int CHUNK     = 8,
    parameter int STAGES    = 3,
    parameter int NUM_ACC   = 4,
    localparam int CW       = $clog2(N) + 1,
    localparam int ACC_W    = $clog2(N * NUM_ACC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x_valid,
    input  logic [N-1:0]     x,
    input  logic             acc_clr,
    output logic             y_valid,
    output logic [CW-1:0]    y,
    output logic             acc_valid,
    output logic [ACC_W-1:0] acc_y
);

    localparam int LEAVES = N / CHUNK;
    localparam int D      = $clog2(LEAVES);
    localparam int R      = STAGES - 1;
    localparam int LEAF_W = $clog2(CHUNK) + 1;
    localparam int CNT_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    function automatic int nodes(input int lvl);
        return (LEAVES + (1 << lvl) - 1) >> lvl;
    endfunction

    // Level D always carries the y register; the other R registers start
    // at the leaves and are spaced evenly over levels 0..D-1.
    function automatic bit reg_at(input int lvl);
        if (lvl == D) return 1'b1;
        for (int k = 0; k < R; k++) begin
            if ((k * D) / R == lvl) return 1'b1;
        end
        return 1'b0;
    endfunction

    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int NN = nodes(l);
        localparam int W  = LEAF_W + l;

        logic [W-1:0] w_c [NN];
        logic [W-1:0] w_q [NN];
        logic         w_vin;
        logic         w_vq;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < NN; j++) begin : g_n
                assign w_c[j] = W'($countones(x[j*CHUNK +: CHUNK]));
            end
            assign w_vin = x_valid;
        end else begin : g_add
            localparam int PN = nodes(l - 1);
            for (genvar j = 0; j < NN; j++) begin : g_n
                if (2 * j + 1 < PN) begin : g_pair
                    assign w_c[j] = W'(g_lvl[l-1].w_q[2*j])
                                  + W'(g_lvl[l-1].w_q[2*j+1]);
                end else begin : g_pass
                    assign w_c[j] = W'(g_lvl[l-1].w_q[2*j]);
                end
            end
            assign w_vin = g_lvl[l-1].w_vq;
        end

        if (reg_at(l)) begin : g_reg
            logic [W-1:0] r_q [NN];
            logic         r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '{default: '0};
                    r_v <= 1'b0;
                end else if (en) begin
                    r_q <= w_c;
                    r_v <= w_vin;
                end
            end

            assign w_q  = r_q;
            assign w_vq = r_v;
        end else begin : g_comb
            assign w_q  = w_c;
            assign w_vq = w_vin;
        end
    end

    assign y       = CW'(g_lvl[D].w_q[0]);
    assign y_valid = g_lvl[D].w_vq;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ACC - 1);

    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc_y;
    logic             r_acc_valid;
    logic [ACC_W-1:0] w_y_ext;

    assign w_y_ext = ACC_W'(y);

    // acc_valid is a one-clock pulse, so it drops even on a stalled edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_cnt       <= '0;
            r_acc_y     <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (en) begin
                if (acc_clr) begin
                    r_sum <= '0;
                    r_cnt <= '0;
                end else if (y_valid) begin
                    if (r_cnt == LAST) begin
                        r_acc_y     <= r_sum + w_y_ext;
                        r_acc_valid <= 1'b1;
                        r_sum       <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_sum <= r_sum + w_y_ext;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign acc_y     = r_acc_y;
    assign acc_valid = r_acc_valid;

endmodule

// File: tb/tb_pop_count_pipe.sv
// Bench for pop_count_pipe: three instances (STAGES 3, 1, 4) on shared
// stimulus, hand tables plus a queue scoreboard and accumulator model.
module tb_pop_count_pipe;

    localparam int NI = 3;
    localparam int ST [NI] = '{3, 1, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        x_valid;
    logic [63:0] x;
    logic        acc_clr;

    logic [6:0]  y_a    [NI];
    logic        yv_a   [NI];
    logic [8:0]  acc_a  [NI];
    logic        accv_a [NI];

    always #5 clk = ~clk;

    pop_count_pipe #(.N(64), .CHUNK(8), .STAGES(3), .NUM_ACC(4)) u_s3 (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .acc_clr(acc_clr), .y_valid(yv_a[0]), .y(y_a[0]),
        .acc_valid(accv_a[0]), .acc_y(acc_a[0])
    );

    pop_count_pipe #(.N(64), .CHUNK(8), .STAGES(1), .NUM_ACC(4)) u_s1 (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .acc_clr(acc_clr), .y_valid(yv_a[1]), .y(y_a[1]),
        .acc_valid(accv_a[1]), .acc_y(acc_a[1])
    );

    pop_count_pipe #(.N(64), .CHUNK(8), .STAGES(4), .NUM_ACC(4)) u_s4 (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .acc_clr(acc_clr), .y_valid(yv_a[2]), .y(y_a[2]),
        .acc_valid(accv_a[2]), .acc_y(acc_a[2])
    );

    typedef struct {
        int e;
        bit v;
        int c;
    } ent_t;

    typedef struct {
        logic [63:0] x;
        bit          xv;
        int          y0;
        bit          v0;
        int          y1;
        bit          v1;
        int          y2;
        bit          v2;
    } lat_t;

    ent_t  sb [$];
    int    rd     [NI];
    int    m_y    [NI];
    bit    m_yv   [NI];
    int    m_sum  [NI];
    int    m_cnt  [NI];
    int    m_acc  [NI];
    bit    m_accv [NI];
    int    k_edge;
    int    n_cmp;
    int    n_err;
    string sn [NI];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit ie, input bit ixv,
                              input logic [63:0] ix, input bit ic,
                              input bit ir);
        ent_t t;
        if (ir) begin
            sb.delete();
            for (int i = 0; i < NI; i++) begin
                rd[i] = 0; m_y[i] = 0; m_yv[i] = 0;
                m_sum[i] = 0; m_cnt[i] = 0;
                m_acc[i] = 0; m_accv[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) m_accv[i] = 0;
            if (ie) begin
                k_edge++;
                t.e = k_edge;
                t.v = ixv;
                t.c = $countones(ix);
                sb.push_back(t);
                for (int i = 0; i < NI; i++) begin
                    if (ic) begin
                        m_sum[i] = 0;
                        m_cnt[i] = 0;
                    end else if (m_yv[i]) begin
                        if (m_cnt[i] == 3) begin
                            m_acc[i]  = m_sum[i] + m_y[i];
                            m_accv[i] = 1;
                            m_sum[i]  = 0;
                            m_cnt[i]  = 0;
                        end else begin
                            m_sum[i] += m_y[i];
                            m_cnt[i]++;
                        end
                    end
                    if (rd[i] < sb.size() &&
                        sb[rd[i]].e + ST[i] - 1 == k_edge) begin
                        m_y[i]  = sb[rd[i]].c;
                        m_yv[i] = sb[rd[i]].v;
                        rd[i]++;
                    end else begin
                        m_yv[i] = 0;
                    end
                end
                while (sb.size() > 0 && rd[0] > 0 && rd[1] > 0 && rd[2] > 0) begin
                    void'(sb.pop_front());
                    for (int i = 0; i < NI; i++) rd[i]--;
                end
            end
        end
    endtask

    task automatic step(input bit ie, input bit ixv, input logic [63:0] ix,
                        input bit ic, input bit ir);
        en = ie; x_valid = ixv; x = ix; acc_clr = ic; rst = ir;
        @(posedge clk);
        model_edge(ie, ixv, ix, ic, ir);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk({sn[i], "_y"},         32'(y_a[i]),    m_y[i]);
            chk({sn[i], "_y_valid"},   32'(yv_a[i]),   32'(m_yv[i]));
            chk({sn[i], "_acc_y"},     32'(acc_a[i]),  m_acc[i]);
            chk({sn[i], "_acc_valid"}, 32'(accv_a[i]), 32'(m_accv[i]));
        end
    endtask

    task automatic acc_run(input string nm, input logic [63:0] s0,
                           input logic [63:0] s1, input logic [63:0] s2,
                           input logic [63:0] s3, input int exp_acc);
        logic [63:0] sv [4];
        int pulse_at;
        int npulse;
        int got;
        sv = '{s0, s1, s2, s3};
        pulse_at = -1;
        npulse = 0;
        got = -1;
        for (int j = 0; j < 10; j++) begin
            if (j < 4) step(1, 1, sv[j], 0, 0);
            else       step(1, 0, 64'h0, 0, 0);
            if (accv_a[0]) begin
                npulse++;
                pulse_at = j;
                got = int'(acc_a[0]);
            end
        end
        chk({nm, "_pulse_step"}, pulse_at, 6);
        chk({nm, "_pulses"}, npulse, 1);
        chk({nm, "_acc_y"}, got, exp_acc);
    endtask

    lat_t tbl [6];
    int   st_en [7];
    int   st_xv [7];
    logic [63:0] st_x [7];
    int   st_yv [7];
    int   st_y  [7];
    logic [63:0] cl_x [13];
    int   cl_pulse;
    int   cl_val;
    int   stray;

    function automatic lat_t mk(input logic [63:0] ix, input bit ixv,
                                input int y0, input bit v0,
                                input int y1, input bit v1,
                                input int y2, input bit v2);
        lat_t r;
        r.x = ix; r.xv = ixv;
        r.y0 = y0; r.v0 = v0;
        r.y1 = y1; r.v1 = v1;
        r.y2 = y2; r.v2 = v2;
        return r;
    endfunction

    initial begin
        n_cmp = 0; n_err = 0; k_edge = 0;
        sn = '{"s3", "s1", "s4"};
        rst = 1; en = 0; x_valid = 0; x = '0; acc_clr = 0;

        // latency: 0, all ones, 0xFF back to back, then bubbles
        tbl[0] = mk(64'h0, 1, 0, 0, 0, 1, 0, 0);
        tbl[1] = mk(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64, 1, 0, 0);
        tbl[2] = mk(64'h0000_0000_0000_00FF, 1, 0, 1, 8, 1, 0, 0);
        tbl[3] = mk(64'h0, 0, 64, 1, 0, 0, 0, 1);
        tbl[4] = mk(64'h0, 0, 8, 1, 0, 0, 64, 1);
        tbl[5] = mk(64'h0, 0, 0, 0, 0, 0, 8, 1);

        // bubble + two-cycle stall, STAGES=3 view
        st_en = '{1, 1, 1, 0, 0, 1, 1};
        st_xv = '{1, 0, 1, 0, 0, 0, 0};
        st_x  = '{64'h1F, 64'h0, 64'h7F, 64'h0, 64'h0, 64'h0, 64'h0};
        st_yv = '{0, 0, 1, 1, 1, 0, 1};
        st_y  = '{0, 0, 5, 5, 5, 0, 7};

        step(0, 0, 64'h0, 0, 1);
        step(1, 1, 64'hFF, 0, 1);
        chk("rst_y", 32'(y_a[0]), 0);
        chk("rst_y_valid", 32'(yv_a[0]), 0);
        chk("rst_acc_y", 32'(acc_a[0]), 0);
        chk("rst_acc_valid", 32'(accv_a[0]), 0);

        for (int r = 0; r < 6; r++) begin
            step(1, tbl[r].xv, tbl[r].x, 0, 0);
            chk($sformatf("lat_s3_y[%0d]", r), 32'(y_a[0]), tbl[r].y0);
            chk($sformatf("lat_s3_v[%0d]", r), 32'(yv_a[0]), 32'(tbl[r].v0));
            chk($sformatf("lat_s1_y[%0d]", r), 32'(y_a[1]), tbl[r].y1);
            chk($sformatf("lat_s1_v[%0d]", r), 32'(yv_a[1]), 32'(tbl[r].v1));
            chk($sformatf("lat_s4_y[%0d]", r), 32'(y_a[2]), tbl[r].y2);
            chk($sformatf("lat_s4_v[%0d]", r), 32'(yv_a[2]), 32'(tbl[r].v2));
        end

        step(1, 0, 64'h0, 0, 1);
        for (int r = 0; r < 7; r++) begin
            step(st_en[r][0], st_xv[r][0], st_x[r], 0, 0);
            chk($sformatf("stall_y[%0d]", r), 32'(y_a[0]), st_y[r]);
            chk($sformatf("stall_v[%0d]", r), 32'(yv_a[0]), st_yv[r]);
        end
        for (int r = 0; r < 4; r++) step(1, 0, 64'h0, 0, 0);

        step(1, 0, 64'h0, 0, 1);
        acc_run("acc97", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'h0000_0000_FFFF_FFFF, 64'h1, 97);
        stray = 0;
        step(1, 1, 64'h3, 0, 0);
        for (int r = 0; r < 5; r++) begin
            step(1, 0, 64'h0, 0, 0);
            if (accv_a[0]) stray++;
        end
        chk("acc_fifth_no_pulse", stray, 0);
        chk("acc_fifth_hold", 32'(acc_a[0]), 97);

        step(1, 0, 64'h0, 0, 1);
        acc_run("acc_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 256);

        // acc_clr lands on the edge that consumes the third count of 10
        step(1, 0, 64'h0, 0, 1);
        cl_x = '{64'h3FF, 64'h3FF, 64'h3FF, 64'h7, 64'h7, 64'h7, 64'h7,
                 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        cl_pulse = -1;
        cl_val = -1;
        for (int j = 0; j < 13; j++) begin
            step(1, (j < 7), cl_x[j], (j == 5), 0);
            if (accv_a[0]) begin
                cl_pulse = j;
                cl_val = int'(acc_a[0]);
            end
        end
        chk("clr_pulse_step", cl_pulse, 9);
        chk("clr_acc_y", cl_val, 12);

        // reset with two samples in flight and the counter at 2
        step(1, 0, 64'h0, 0, 1);
        step(1, 1, 64'h1, 0, 0);
        step(1, 1, 64'h3, 0, 0);
        step(1, 1, 64'h7, 0, 0);
        step(1, 1, 64'hF, 0, 0);
        step(1, 0, 64'h0, 0, 0);
        chk("pre_rst_y_valid", 32'(yv_a[0]), 1);
        step(1, 1, 64'hFF, 0, 1);
        chk("mid_rst_y", 32'(y_a[0]), 0);
        chk("mid_rst_y_valid", 32'(yv_a[0]), 0);
        chk("mid_rst_acc_y", 32'(acc_a[0]), 0);
        chk("mid_rst_acc_valid", 32'(accv_a[0]), 0);
        stray = 0;
        for (int r = 0; r < 4; r++) begin
            step(1, 0, 64'h0, 0, 0);
            if (yv_a[0]) stray++;
        end
        chk("flushed_no_valid", stray, 0);
        acc_run("post_rst", 64'h1F, 64'h3F, 64'h7F, 64'hFF, 26);

        step(1, 0, 64'h0, 0, 1);
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 {$urandom, $urandom}, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
